// File: rtl/fht_input_loader.sv
// fht_input_loader: streams a frame of N = 4*2^A_BIT samples into four FHT
// memory banks and then hands the frame over to the FHT control block.
//
// Handshake: a sample is taken on every rising edge where iVALID and oREADY
// are both high and iCLR is low; oREADY depends on the state only, never on
// iVALID, so the producer may hold iVALID high indefinitely.
//
// Optional feature: define FHT_LOADER_BIT_REV_EN to scatter samples in
// bit-reversed order (r = bitrev(k)); otherwise samples are stored in
// natural order (r = k). In both cases bank = r[1:0], address = r[msb:2].
//
// oSTATE is a debug view of the FSM state for checkers.

module fht_input_loader #(
    parameter int A_BIT = 8,
    parameter int D_BIT = 16
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [D_BIT-1:0] iDATA,
    input  logic             iVALID,
    output logic             oREADY,
    input  logic             iCLR,
    input  logic             iFHT_RDY,
    output logic             oSTART,
    output logic [A_BIT-1:0] oADDR_WR,
    output logic [D_BIT-1:0] oDATA,
    output logic [3:0]       oWE,
    output logic             oBUSY,
    output logic [2:0]       oSTATE
);

    localparam int K_BIT = A_BIT + 2;
    localparam logic [K_BIT-1:0] K_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [K_BIT-1:0]   k_q, k_d;
    logic [K_BIT-1:0]   r;
    logic               accept;
    logic               start_q, start_d;
    logic [3:0]         we_q, we_d;
    logic [A_BIT-1:0]   addr_q;
    logic [D_BIT-1:0]   data_q;

    assign oREADY = (state_q == S_LOAD);
    assign accept = iVALID && oREADY && !iCLR;

`ifdef FHT_LOADER_BIT_REV_EN
    // Storage index is the sample counter with its bits reversed
    always_comb begin
        r = '0;
        for (int i = 0; i < K_BIT; i++) begin
            r[i] = k_q[K_BIT-1-i];
        end
    end
`else
    assign r = k_q;
`endif

    // Write strobe for the sample accepted this cycle (one-hot bank select)
    always_comb begin
        we_d = 4'b0000;
        if (accept) begin
            we_d = 4'b0001 << r[1:0];
        end
    end

    // Next-state logic; iCLR wins over everything, including acceptance
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        start_d = 1'b0;
        if (iCLR) begin
            state_d = S_IDLE;
            k_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (iFHT_RDY) state_d = S_LOAD;
                end
                S_LOAD: begin
                    if (accept) begin
                        if (k_q == K_LAST) begin
                            k_d     = '0;
                            state_d = S_START;
                            start_d = 1'b1;
                        end else begin
                            k_d = k_q + 1'b1;
                        end
                    end
                end
                S_START: begin
                    state_d = S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (!iFHT_RDY) state_d = S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (iFHT_RDY) state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, counter and registered outputs; the last write lands with oSTART
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            start_q <= 1'b0;
            we_q    <= 4'b0000;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            start_q <= start_d;
            we_q    <= we_d;
            if (accept) begin
                addr_q <= r[K_BIT-1:2];
                data_q <= iDATA;
            end
        end
    end

    assign oSTART   = start_q;
    assign oWE      = we_q;
    assign oADDR_WR = addr_q;
    assign oDATA    = data_q;
    assign oBUSY    = (state_q != S_IDLE);
    assign oSTATE   = state_q;

endmodule
